rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among three writeback sources:
  - main pipeline (P): highest priority, no backpressure;
  - load unit (L): valid/ready;
  - mul/div unit (M): valid/ready.
- Registers the winning write onto the regfile port.
- Runs an anti-starvation FSM that asks the pipeline to stall.
- Keeps a pending-write scoreboard so issue logic can detect hazards on long-latency destinations.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles L/M may be blocked by P before stall_req is raised (legal range 1..15).
- DATA_W, 32, write data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_we  in  1  pipeline writeback valid.
- p_waddr  in  5  pipeline destination register.
- p_wdata  in  DATA_W  pipeline write data.
- stall_req  out  1  registered; pipeline must hold p_we low while it is high.
- l_valid  in  1  load-unit writeback valid.
- l_ready  out  1  load-unit grant.
- l_waddr  in  5  load-unit destination register.
- l_wdata  in  DATA_W  load-unit write data.
- m_valid  in  1  mul/div writeback valid.
- m_ready  out  1  mul/div grant.
- m_waddr  in  5  mul/div destination register.
- m_wdata  in  DATA_W  mul/div write data.
- sb_set  in  1  mark a long-latency destination pending.
- sb_addr  in  5  register to mark.
- chk_addr1  in  5  scoreboard lookup address, port 1.
- chk_addr2  in  5  scoreboard lookup address, port 2.
- chk_busy1  out  1  busy bit for chk_addr1.
- chk_busy2  out  1  busy bit for chk_addr2.
- rf_we  out  1  regfile write enable.
- rf_waddr  out  5  regfile write address.
- rf_wdata  out  DATA_W  regfile write data.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - stall_req=0, rr=0, wait_cnt=0, state=IDLE, busy[31:0]=0;
  - in-flight requests are not remembered.
- Grant (combinational, same cycle):
  - p_we=1: P wins; l_ready=m_ready=0.
  - Else if only one of l_valid/m_valid is high: that source's ready=1.
  - Else if both are high: rr=0 grants L, rr=1 grants M.
  - ready never asserts without its own valid.
  - Sources must hold valid/addr/data stable until ready; valid must not depend on ready.
- Round-robin: on each L grant rr<=1; on each M grant rr<=0; otherwise rr holds.
- Write port (latency 1):
  - At the edge after a grant: rf_we<=1 iff winner's waddr!=0; rf_waddr/rf_wdata <= winner's values.
  - With no grant: rf_we<=0 and rf_waddr/rf_wdata hold.
  - Writes to r0 complete the handshake but are suppressed (rf_we=0).
- Starvation FSM, blocked = (l_valid|m_valid) & p_we:
  - IDLE: blocked -> CONTEND with wait_cnt<=1; if STARVE_LIMIT=1, go directly to STALL.
  - CONTEND: blocked -> wait_cnt+1; when wait_cnt+1==STARVE_LIMIT go to STALL. Any L/M grant, or neither valid -> IDLE, wait_cnt<=0.
  - STALL: stall_req=1 (registered from state). Any L/M grant -> IDLE, wait_cnt<=0, stall_req low next cycle. Both valids dropping -> IDLE.
  - If p_we is high during STALL (protocol violation), P still wins, no write is lost, and the FSM stays in STALL.
- Scoreboard:
  - sb_set & sb_addr!=0 sets busy[sb_addr].
  - An L or M handshake clears busy[waddr].
  - Set and clear of the same register in the same cycle: set wins.
  - P writes never touch busy; busy[0] is constant 0.
  - chk_busyN = busy[chk_addrN], combinational from registered state; same-cycle set/clear is not bypassed.

Test Plan:
- Reset mid-grant: hold l_valid=1, assert reset for 1 cycle -> all outputs 0; after release, l_ready=1 and rf_we=1 one cycle later with l_waddr/l_wdata.
- Priority: p_we=1 (addr 3, 0xAAAA0000) with l_valid=1 (addr 4) -> l_ready=0; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xAAAA0000; drop p_we -> L granted, rf_waddr=4 the following cycle.
- Round-robin: l_valid=m_valid=1 held for 4 cycles after reset -> grants L,M,L,M; rf_waddr alternates l_waddr/m_waddr.
- Starvation (STARVE_LIMIT=4): p_we=1 every cycle, m_valid=1 -> stall_req rises after the 4th blocked cycle; bench drops p_we -> m_ready=1, stall_req=0 the next cycle.
- r0 and scoreboard:
  - sb_set addr 7, then chk_addr1=7 -> chk_busy1=1;
  - M handshake to r7 -> chk_busy1=0 next cycle;
  - sb_set addr 0 -> busy stays 0;
  - L write to r0 -> l_ready=1, rf_we=0.
- Set/clear collision: sb_set addr 9 in the same cycle as an L handshake to r9 -> chk_busy for 9 remains 1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port among the pipeline, load and mul/div writebacks; write lands 1 cycle after grant.
// Pipeline never backpressured; L/M wait on ready, with a registered stall_req raised after STARVE_LIMIT blocked cycles.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_we,
    input  logic [4:0]        p_waddr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              stall_req,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [4:0]        l_waddr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [4:0]        m_waddr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              sb_set,
    input  logic [4:0]        sb_addr,
    input  logic [4:0]        chk_addr1,
    input  logic [4:0]        chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    typedef enum logic [1:0] {IDLE, CONTEND, STALL} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        rr;
    logic [31:1] busy;
    logic [31:0] busy_vec;
    logic        l_gnt, m_gnt, lm_gnt, any_valid, blocked;

    // Grants are masked during reset so no handshake completes while state is being cleared.
    always_comb begin
        l_gnt = 1'b0;
        m_gnt = 1'b0;
        if (!reset && !p_we) begin
            if (l_valid && m_valid) begin
                l_gnt = !rr;
                m_gnt = rr;
            end else begin
                l_gnt = l_valid;
                m_gnt = m_valid;
            end
        end
    end

    assign l_ready   = l_gnt;
    assign m_ready   = m_gnt;
    assign lm_gnt    = l_gnt | m_gnt;
    assign any_valid = l_valid | m_valid;
    assign blocked   = any_valid & p_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (p_we) begin
            rf_we    <= (p_waddr != 5'd0);
            rf_waddr <= p_waddr;
            rf_wdata <= p_wdata;
        end else if (l_gnt) begin
            rf_we    <= (l_waddr != 5'd0);
            rf_waddr <= l_waddr;
            rf_wdata <= l_wdata;
        end else if (m_gnt) begin
            rf_we    <= (m_waddr != 5'd0);
            rf_waddr <= m_waddr;
            rf_wdata <= m_wdata;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (l_gnt) begin
            rr <= 1'b1;
        end else if (m_gnt) begin
            rr <= 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (blocked) begin
                    wait_cnt_nxt = 4'd1;
                    state_nxt    = (LIMIT == 4'd1) ? STALL : CONTEND;
                end
            end
            CONTEND: begin
                if (lm_gnt || !any_valid) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (blocked) begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                    if (wait_cnt + 4'd1 == LIMIT) begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                // A p_we during STALL just keeps us here; P still owns the port.
                if (lm_gnt || !any_valid) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            stall_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            stall_req <= (state_nxt == STALL);
        end
    end

    // Set beats clear so a re-issued long-latency op on the same register stays tracked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (sb_set && sb_addr == 5'(i)) begin
                    busy[i] <= 1'b1;
                end else if ((l_gnt && l_waddr == 5'(i)) || (m_gnt && m_waddr == 5'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec  = {busy, 1'b0};
    assign chk_busy1 = busy_vec[chk_addr1];
    assign chk_busy2 = busy_vec[chk_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboarded random/directed bench for rf_wb_arbiter against a rule-level reference model.
module tb_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        stall_req;
    logic        l_valid, l_ready;
    logic [4:0]  l_waddr;
    logic [31:0] l_wdata;
    logic        m_valid, m_ready;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        sb_set;
    logic [4:0]  sb_addr, chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata), .stall_req(stall_req),
        .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .sb_set(sb_set), .sb_addr(sb_addr), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;

    // Reference model: who was served last, how long L/M have been shut out, pending registers.
    logic        last_was_l;
    int          shut_out;
    logic        stall_m;
    logic [31:0] busy_m;
    int          last_win;   // 0 none, 1 P, 2 L, 3 M

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        if (a != 5'd0) exp_q.push_back(w);
    endtask

    task automatic idle_inputs();
        p_we = 0; p_waddr = 0; p_wdata = 0;
        l_valid = 0; l_waddr = 0; l_wdata = 0;
        m_valid = 0; m_waddr = 0; m_wdata = 0;
        sb_set = 0; sb_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step();
        int win;
        #2;
        if (p_we)                    win = 1;
        else if (l_valid && m_valid) win = last_was_l ? 3 : 2;
        else if (l_valid)            win = 2;
        else if (m_valid)            win = 3;
        else                         win = 0;
        chk("l_ready", 32'(l_ready), 32'(win == 2));
        chk("m_ready", 32'(m_ready), 32'(win == 3));
        chk("stall_req", 32'(stall_req), 32'(stall_m));
        chk("chk_busy1", 32'(chk_busy1), 32'(busy_m[chk_addr1]));
        chk("chk_busy2", 32'(chk_busy2), 32'(busy_m[chk_addr2]));
        case (win)
            1: push_wr(p_waddr, p_wdata);
            2: begin push_wr(l_waddr, l_wdata); last_was_l = 1'b1; busy_m[l_waddr] = 1'b0; end
            3: begin push_wr(m_waddr, m_wdata); last_was_l = 1'b0; busy_m[m_waddr] = 1'b0; end
            default: ;
        endcase
        if (sb_set && sb_addr != 5'd0) busy_m[sb_addr] = 1'b1;
        if (win == 2 || win == 3 || !(l_valid || m_valid)) shut_out = 0;
        else if (p_we && shut_out < 255) shut_out = shut_out + 1;
        stall_m  = (shut_out >= LIMIT);
        last_win = win;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        chk("rst_l_ready", 32'(l_ready), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_chk_busy1", 32'(chk_busy1), 32'd0);
        last_was_l = 1'b0;
        shut_out   = 0;
        stall_m    = 1'b0;
        busy_m     = '0;
        last_win   = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every regfile write the DUT performs must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset && rf_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rf_write unexpected addr=%0d data=%h at %0t", rf_waddr, rf_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                        bad++;
                        $display("FAIL rf_write got=%0d/%h want=%0d/%h at %0t",
                                 rf_waddr, rf_wdata, e.addr, e.data, $time);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset while L is presenting a write.
        l_valid = 1; l_waddr = 5; l_wdata = 32'h1234_5678;
        do_reset();
        step();
        l_valid = 0;
        step();

        // Pipeline priority over L.
        p_we = 1; p_waddr = 3; p_wdata = 32'hAAAA_0000;
        l_valid = 1; l_waddr = 4; l_wdata = 32'h4444_4444;
        step();
        p_we = 0;
        step();
        l_valid = 0;
        step();

        // Round-robin between L and M.
        idle_inputs();
        do_reset();
        l_valid = 1; l_waddr = 10; l_wdata = 32'h0A0A_0A0A;
        m_valid = 1; m_waddr = 11; m_wdata = 32'h0B0B_0B0B;
        repeat (4) step();
        idle_inputs();
        step();

        // Starvation, including a p_we that ignores stall_req.
        do_reset();
        m_valid = 1; m_waddr = 12; m_wdata = 32'hC0C0_C0C0;
        for (int i = 0; i < 5; i++) begin
            p_we = 1; p_waddr = 5'($urandom_range(1, 31)); p_wdata = $urandom;
            step();
        end
        p_we = 0;
        step();
        m_valid = 0;
        step();
        step();

        // Scoreboard and r0 writes.
        do_reset();
        sb_set = 1; sb_addr = 7; chk_addr1 = 7;
        step();
        sb_set = 0;
        step();
        m_valid = 1; m_waddr = 7; m_wdata = 32'h7777_0007;
        step();
        m_valid = 0;
        step();
        sb_set = 1; sb_addr = 0; chk_addr1 = 0;
        step();
        sb_set = 0;
        step();
        l_valid = 1; l_waddr = 0; l_wdata = 32'hDEAD_BEEF;
        step();
        l_valid = 0;
        step();

        // Set and clear of the same register in one cycle.
        sb_set = 1; sb_addr = 9; chk_addr2 = 9;
        step();
        l_valid = 1; l_waddr = 9; l_wdata = 32'h9999_0009;
        step();
        sb_set = 0; l_valid = 0;
        step();
        step();

        // Random traffic obeying the source protocols.
        idle_inputs();
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (last_win == 2 || !l_valid) begin
                l_valid = ($urandom % 3) == 0;
                l_waddr = 5'($urandom % 16);
                l_wdata = $urandom;
            end
            if (last_win == 3 || !m_valid) begin
                m_valid = ($urandom % 3) == 0;
                m_waddr = 5'($urandom % 16);
                m_wdata = $urandom;
            end
            p_we      = stall_m ? 1'b0 : (($urandom % 2) == 0);
            p_waddr   = 5'($urandom % 16);
            p_wdata   = $urandom;
            sb_set    = ($urandom % 4) == 0;
            sb_addr   = 5'($urandom % 16);
            chk_addr1 = 5'($urandom % 16);
            chk_addr2 = 5'($urandom % 16);
            step();
        end

        idle_inputs();
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
